// File: rtl/register_file.sv
// -----------------------------------------------------------------------------
// register_file
//   Architectural register file for the CPU datapath. It has two combinational
//   read ports that feed the ALU operand muxes and one synchronous write port
//   that is driven from write-back. Register 0 always reads as zero. A
//   same-cycle write-to-read bypass lets decode see the value that write-back
//   is committing in the current cycle.
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset; clears every register
//   wr_en     in   write enable, sampled on rising clk
//   wr_addr   in   destination register
//   wr_data   in   write-back data
//   rd_addr1  in   read port 1 address (rs)
//   rd_addr2  in   read port 2 address (rt)
//   rd_data1  out  read port 1 data, combinational
//   rd_data2  out  read port 2 data, combinational
// -----------------------------------------------------------------------------
module register_file #(
  parameter int unsigned width      = 32,
  parameter int unsigned addr_width = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [addr_width-1:0] wr_addr,
  input  logic [width-1:0]      wr_data,
  input  logic [addr_width-1:0] rd_addr1,
  input  logic [addr_width-1:0] rd_addr2,
  output logic [width-1:0]      rd_data1,
  output logic [width-1:0]      rd_data2
);

  localparam int unsigned depth = 2 ** addr_width;

  // Entry 0 is held at its reset value and never written, so it reduces to
  // constant zero. The read mux also forces address 0 to zero, so the entry
  // is never observed.
  logic [width-1:0] regs_q [depth];
  logic [width-1:0] regs_d [depth];

  logic wr_fire;
  logic bypass_en;

  // A write to r0 is dropped here. That also removes r0 from the bypass path,
  // because address 0 has the highest read priority.
  assign wr_fire   = wr_en && (wr_addr != '0);
  // No bypass during reset, so both ports read zero while rst_n is low.
  assign bypass_en = rst_n && wr_en;

  always_comb begin
    // NOTE: combinational next-state logic uses blocking '=' with a full
    // default first. The sequential block below uses only non-blocking '<='.
    regs_d = regs_q;
    if (wr_fire) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // NOTE: this storage is a bank of flops, not a RAM macro. It must clear
  // asynchronously, so the whole array sits in the reset branch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read priority: the zero register first, then the in-flight write, then storage.
  function automatic logic [width-1:0] read_port(
    input logic [addr_width-1:0] addr,
    input logic [width-1:0]      stored
  );
    if (addr == '0) begin
      return '0;
    end else if (bypass_en && (wr_addr == addr)) begin
      return wr_data;
    end else begin
      return stored;
    end
  endfunction

  always_comb begin
    rd_data1 = read_port(rd_addr1, regs_q[rd_addr1]);
  end

  always_comb begin
    rd_data2 = read_port(rd_addr2, regs_q[rd_addr2]);
  end

endmodule

// File: tb/tb_register_file.sv
// -----------------------------------------------------------------------------
// tb_register_file
//   Scoreboard bench for register_file. The stimulus process drives the ports
//   and pushes the expected read data, taken from an architectural model, into
//   a queue. A separate monitor pops each entry when it is signalled and
//   compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_register_file;

  localparam int W  = 32;
  localparam int AW = 5;
  localparam int N  = 32;

  logic          clk      = 1'b0;
  logic          rst_n    = 1'b0;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [W-1:0]  wr_data  = '0;
  logic [AW-1:0] rd_addr1 = '0;
  logic [AW-1:0] rd_addr2 = '0;
  logic [W-1:0]  rd_data1;
  logic [W-1:0]  rd_data2;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    string        name;
    logic [W-1:0] exp1;
    logic [W-1:0] exp2;
  } exp_t;

  exp_t exp_q[$];
  event sample_ev;

  register_file #(.width(W), .addr_width(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  always #10 clk = ~clk;

  // Architectural model: a plain array holding the committed register values.
  logic [W-1:0] model [N] = '{default: '0};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (model[i]) model[i] = '0;
    end else if (wr_en && wr_addr != 0) begin
      model[wr_addr] = wr_data;
    end
  end

  // Expected read value. It applies the architectural rules directly to the
  // model and to the write currently on the bus.
  function automatic logic [W-1:0] ref_read(input logic [AW-1:0] a);
    if (!rst_n)                        return '0;
    if (a == 0)                        return '0;
    if (wr_en && wr_addr == a)         return wr_data;
    return model[a];
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: it takes one expectation for each sample event.
  initial begin
    exp_t e;
    forever begin
      @(sample_ev);
      if (exp_q.size() == 0) begin
        check("monitor_underflow", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check({e.name, ".p1"}, rd_data1, e.exp1);
        check({e.name, ".p2"}, rd_data2, e.exp2);
      end
    end
  end

  // Drive the read addresses, let them settle, record the expectation and
  // signal the monitor. The task takes 2 ns and stays clear of clock edges.
  task automatic check_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2, input string name);
    exp_t e;
    rd_addr1 = a1;
    rd_addr2 = a2;
    #1;
    e.name = name;
    e.exp1 = ref_read(a1);
    e.exp2 = ref_read(a2);
    exp_q.push_back(e);
    -> sample_ev;
    #1;
  endtask

  task automatic drive_write(input logic en, input logic [AW-1:0] a, input logic [W-1:0] d);
    wr_en   = en;
    wr_addr = a;
    wr_data = d;
  endtask

  initial begin
    // Reset state at power-up.
    repeat (2) @(negedge clk);
    check_read(5'd0, 5'd31, "power_on_reset");

    // Load some content, then pulse reset between edges and sweep every address.
    rst_n = 1'b1;
    @(negedge clk); drive_write(1'b1, 5'd5, 32'h0000_0055);
    @(negedge clk); drive_write(1'b1, 5'd9, 32'h0000_0099);
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    check_read(5'd5, 5'd9, "preload");
    #2 rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      check_read(AW'(i), AW'(N - 1 - i), "reset_sweep");
    end
    // A write attempted while reset is held must not land.
    @(negedge clk); drive_write(1'b1, 5'd5, 32'hDEAD_BEEF);
    check_read(5'd5, 5'd5, "write_in_reset");
    repeat (2) @(posedge clk);
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    check_read(5'd5, 5'd5, "write_in_reset_after");

    // Write rN = N on consecutive cycles, then sweep both ports in opposite directions.
    for (int i = 1; i < N; i++) begin
      @(negedge clk); drive_write(1'b1, AW'(i), W'(i));
    end
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    for (int i = 0; i < N; i++) begin
      @(negedge clk);
      check_read(AW'(i), AW'(N - 1 - i), "sweep");
    end

    // A write to register 0 is dropped and is not bypassed either.
    @(negedge clk); drive_write(1'b1, 5'd0, 32'hFFFF_FFFF);
    check_read(5'd0, 5'd0, "r0_same_cycle");
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_read(5'd0, 5'd0, "r0_later");
    end

    // Bypass on both ports, then the stored value once wr_en drops (no edge in between).
    @(negedge clk); drive_write(1'b1, 5'd7, 32'h1111_1111);
    @(negedge clk); drive_write(1'b1, 5'd7, 32'h2222_2222);
    check_read(5'd7, 5'd7, "bypass_on");
    drive_write(1'b0, 5'd7, 32'h2222_2222);
    check_read(5'd7, 5'd7, "bypass_off");

    // Independent ports: one reads storage while the other bypasses.
    @(negedge clk); drive_write(1'b1, 5'd3, 32'hAAAA_0000);
    @(negedge clk); drive_write(1'b1, 5'd4, 32'h0000_5555);
    check_read(5'd3, 5'd4, "indep_bypass");
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    check_read(5'd3, 5'd4, "indep_stored");

    // Back-to-back writes to one register: the last edge wins.
    @(negedge clk); drive_write(1'b1, 5'd12, 32'h0000_0AAA);
    @(negedge clk); drive_write(1'b1, 5'd12, 32'h0000_0BBB);
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    check_read(5'd12, 5'd12, "last_write_wins");

    // Reset asserted mid-cycle with a write pending: the read drops with no edge.
    @(negedge clk); drive_write(1'b1, 5'd10, 32'h1234_5678);
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    check_read(5'd10, 5'd10, "mid_reset_loaded");
    drive_write(1'b1, 5'd11, 32'h0000_CAFE);
    #2 rst_n = 1'b0;
    check_read(5'd10, 5'd11, "mid_reset_async");
    @(negedge clk); drive_write(1'b0, 5'd0, 32'h0);
    rst_n = 1'b1;
    check_read(5'd10, 5'd11, "mid_reset_released");

    // Randomised traffic with occasional mid-cycle reset pulses.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      rst_n = 1'b1;
      drive_write(1'($urandom_range(1, 0)), AW'($urandom_range(N - 1, 0)), $urandom);
      if ($urandom_range(3, 0) == 0) begin
        check_read(wr_addr, AW'($urandom_range(N - 1, 0)), "rand_bypass");
      end else begin
        check_read(AW'($urandom_range(N - 1, 0)), AW'($urandom_range(N - 1, 0)), "rand");
      end
      if ($urandom_range(31, 0) == 0) begin
        #2 rst_n = 1'b0;
        check_read(AW'($urandom_range(N - 1, 0)), AW'($urandom_range(N - 1, 0)), "rand_reset");
      end
    end

    @(negedge clk);
    rst_n = 1'b1;
    drive_write(1'b0, 5'd0, 32'h0);
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
